// File: rtl/amp_i2c_target.sv
// I2C target endpoint driving an 8-bit register-file port; scl/sda are oversampled on clk.
// Define I2C_GLITCH_FILTER_EN to require 3 stable clk samples before a line change is accepted.
module amp_i2c_target #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_raw, sda_raw, scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_raw = scl_sync[SYNC_STAGES-1];
  assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_s    <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_raw};
      sda_hist <= {sda_hist[0], sda_raw};
      if (scl_raw == scl_hist[0] && scl_raw == scl_hist[1]) scl_s <= scl_raw;
      if (sda_raw == sda_hist[0] && sda_raw == sda_hist[1]) sda_s <= sda_raw;
    end
  end
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shifter, shifter_n, byte_in;
  logic [7:0] reg_addr_n, reg_wdata_n;
  logic       sda_oe_n, reg_wr_en_n, reg_rd_en_n, busy_n;
  logic       rw, rw_n, load_pend, load_pend_n, inc_pend, inc_pend_n, ack_seen, ack_seen_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shifter   <= '0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;
      ack_seen  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shifter   <= shifter_n;
      sda_oe    <= sda_oe_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_wr_en <= reg_wr_en_n;
      reg_rd_en <= reg_rd_en_n;
      busy      <= busy_n;
      rw        <= rw_n;
      load_pend <= load_pend_n;
      inc_pend  <= inc_pend_n;
      ack_seen  <= ack_seen_n;
    end
  end

  assign byte_in = {shifter[6:0], sda_s};

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shifter_n   = shifter;
    sda_oe_n    = sda_oe;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    reg_wr_en_n = 1'b0;
    reg_rd_en_n = 1'b0;
    busy_n      = busy;
    rw_n        = rw;
    load_pend_n = reg_rd_en;
    inc_pend_n  = 1'b0;
    ack_seen_n  = ack_seen;
    // read data arrives the cycle after reg_rd_en; pointer bump lags the write strobe by one cycle
    if (load_pend) shifter_n = reg_rdata;
    if (inc_pend) reg_addr_n = reg_addr + 8'd1;

    if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: sda_oe_n = 1'b0;
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shifter_n = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (state == ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_n = ADDR_ACK;
                  busy_n  = 1'b1;
                  rw_n    = byte_in[0];
                end else begin
                  state_n = IDLE;
                end
              end else if (state == REG) begin
                reg_addr_n = byte_in;
                state_n    = REG_ACK;
              end else begin
                reg_wdata_n = byte_in;
                reg_wr_en_n = 1'b1;
                inc_pend_n  = 1'b1;
                state_n     = WDATA_ACK;
              end
            end
          end
        end
        // sda_oe doubles as the ACK phase: first fall starts driving, second fall ends the ACK
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_rise && sda_oe && state == ADDR_ACK && rw) reg_rd_en_n = 1'b1;
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              bit_cnt_n = '0;
              if (state == ADDR_ACK && rw) begin
                state_n  = RDATA;
                sda_oe_n = ~shifter[7];
              end else begin
                state_n  = (state == ADDR_ACK) ? REG : WDATA;
                sda_oe_n = 1'b0;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) bit_cnt_n = bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n   = 1'b0;
              state_n    = RDATA_ACK;
              ack_seen_n = 1'b0;
            end else begin
              shifter_n = {shifter[6:0], 1'b0};
              sda_oe_n  = ~shifter[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && !ack_seen) begin
            if (!sda_s) begin
              ack_seen_n  = 1'b1;
              reg_addr_n  = reg_addr + 8'd1;
              reg_rd_en_n = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
          if (scl_fall && ack_seen) begin
            state_n   = RDATA;
            sda_oe_n  = ~shifter[7];
            bit_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amp_i2c_target.sv
// Directed bench for amp_i2c_target: bit-banged I2C controller, open-drain bus and register model.
module tb_amp_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_ctl, sda_ctl, sda_bus;
  logic       sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  assign sda_bus = sda_ctl & ~sda_oe;

  amp_i2c_target #(.SLAVE_ADDR(7'h20), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_ctl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    case (a)
      8'h35:   return 8'h08;
      8'h36:   return 8'hA5;
      default: return a ^ 8'h5C;
    endcase
  endfunction

  always @(posedge clk) if (reg_rd_en) reg_rdata <= mem_val(reg_addr);

  int         wr_cnt = 0, rd_cnt = 0, busy_cyc = 0, oe_cyc = 0;
  logic [7:0] wa_log [64];
  logic [7:0] wd_log [64];

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wa_log[wr_cnt[5:0]] <= reg_addr;
      wd_log[wr_cnt[5:0]] <= reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (sda_oe) oe_cyc <= oe_cyc + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_ctl = 1'b1; clks(Q);
    scl_ctl = 1'b1; clks(Q);
    sda_ctl = 1'b0; clks(Q);
    scl_ctl = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_ctl = 1'b0; clks(Q);
    scl_ctl = 1'b1; clks(Q);
    sda_ctl = 1'b1; clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_ctl = b;    clks(Q);
    scl_ctl = 1'b1; clks(2 * Q);
    scl_ctl = 1'b0; clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_ctl = 1'b1; clks(Q);
    scl_ctl = 1'b1; clks(Q);
    b = sda_bus;    clks(Q);
    scl_ctl = 1'b0; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    int         nwr;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       a0, a1, a2, a3, a4;
    logic [7:0] rd0, rd1;
    int         w0, r0, b0, o0;

    vecs[0] = '{dev: 8'h40, ptr: 8'h40, data: 8'h18, exp_ack: 1'b1, nwr: 1, exp_addr: 8'h41};
    vecs[1] = '{dev: 8'h42, ptr: 8'h00, data: 8'h00, exp_ack: 1'b0, nwr: 0, exp_addr: 8'h41};
    vecs[2] = '{dev: 8'h40, ptr: 8'hFF, data: 8'h5A, exp_ack: 1'b1, nwr: 1, exp_addr: 8'h00};
    vecs[3] = '{dev: 8'h40, ptr: 8'h00, data: 8'hC3, exp_ack: 1'b1, nwr: 1, exp_addr: 8'h01};
    vecs[4] = '{dev: 8'h22, ptr: 8'h10, data: 8'h99, exp_ack: 1'b0, nwr: 0, exp_addr: 8'h01};
    vecs[5] = '{dev: 8'h40, ptr: 8'h7F, data: 8'h00, exp_ack: 1'b1, nwr: 1, exp_addr: 8'h80};

    reset = 1'b0; scl_ctl = 1'b1; sda_ctl = 1'b1;
    clks(3);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_reg_addr", {24'd0, reg_addr}, 0);
    chk("rst_reg_wdata", {24'd0, reg_wdata}, 0);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 0);
    chk("rst_rd_en", {31'd0, reg_rd_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    clks(5);

    // single-byte write transactions
    foreach (vecs[k]) begin
      w0 = wr_cnt; b0 = busy_cyc; o0 = oe_cyc;
      i2c_start();
      write_byte(vecs[k].dev, a0);
      chk($sformatf("v%0d_dev_ack", k), {31'd0, a0}, {31'd0, vecs[k].exp_ack});
      if (a0) begin
        write_byte(vecs[k].ptr, a1);
        write_byte(vecs[k].data, a2);
        chk($sformatf("v%0d_ptr_ack", k), {31'd0, a1}, 1);
        chk($sformatf("v%0d_data_ack", k), {31'd0, a2}, 1);
      end
      i2c_stop();
      clks(10);
      chk($sformatf("v%0d_nwr", k), wr_cnt - w0, vecs[k].nwr);
      if (vecs[k].nwr == 1) begin
        chk($sformatf("v%0d_wr_addr", k), {24'd0, wa_log[w0[5:0]]}, {24'd0, vecs[k].ptr});
        chk($sformatf("v%0d_wr_data", k), {24'd0, wd_log[w0[5:0]]}, {24'd0, vecs[k].data});
      end
      chk($sformatf("v%0d_reg_addr", k), {24'd0, reg_addr}, {24'd0, vecs[k].exp_addr});
      chk($sformatf("v%0d_busy_after", k), {31'd0, busy}, 0);
      if (!vecs[k].exp_ack) begin
        chk($sformatf("v%0d_no_busy", k), busy_cyc - b0, 0);
        chk($sformatf("v%0d_no_oe", k), oe_cyc - o0, 0);
      end
    end

    // burst write wrapping through 0xFF
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h40, a0); write_byte(8'hFE, a1);
    write_byte(8'h11, a2); write_byte(8'h22, a3); write_byte(8'h33, a4);
    i2c_stop();
    clks(10);
    chk("burst_acks", {27'd0, a0, a1, a2, a3, a4}, 32'h1F);
    chk("burst_nwr", wr_cnt - w0, 3);
    chk("burst_w0", {wa_log[w0[5:0]], wd_log[w0[5:0]]}, 32'hFE11);
    chk("burst_w1", {wa_log[6'(w0 + 1)], wd_log[6'(w0 + 1)]}, 32'hFF22);
    chk("burst_w2", {wa_log[6'(w0 + 2)], wd_log[6'(w0 + 2)]}, 32'h0033);
    chk("burst_final_addr", {24'd0, reg_addr}, 32'h01);

    // pointer write then repeated-START read of two bytes
    r0 = rd_cnt; w0 = wr_cnt;
    i2c_start();
    write_byte(8'h40, a0); write_byte(8'h35, a1);
    i2c_start();
    write_byte(8'h41, a2);
    chk("rd_acks", {29'd0, a0, a1, a2}, 32'h7);
    read_byte(1'b0, rd0);
    read_byte(1'b1, rd1);
    chk("rd_byte0", {24'd0, rd0}, 32'h08);
    chk("rd_byte1", {24'd0, rd1}, 32'hA5);
    clks(4);
    chk("rd_released", {31'd0, sda_oe}, 0);
    chk("rd_count", rd_cnt - r0, 2);
    chk("rd_no_write", wr_cnt - w0, 0);
    i2c_stop();
    clks(10);
    chk("rd_busy_after", {31'd0, busy}, 0);
    chk("rd_final_addr", {24'd0, reg_addr}, 32'h36);

    // STOP after four data bits, then a normal transaction
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h40, a0); write_byte(8'h50, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    clks(10);
    chk("mid_stop_nwr", wr_cnt - w0, 0);
    chk("mid_stop_oe", {31'd0, sda_oe}, 0);
    chk("mid_stop_busy", {31'd0, busy}, 0);
    chk("mid_stop_addr", {24'd0, reg_addr}, 32'h50);
    i2c_start();
    write_byte(8'h40, a0); write_byte(8'h60, a1); write_byte(8'h77, a2);
    i2c_stop();
    clks(10);
    chk("after_stop_acks", {29'd0, a0, a1, a2}, 32'h7);
    chk("after_stop_nwr", wr_cnt - w0, 1);
    chk("after_stop_wr", {wa_log[w0[5:0]], wd_log[w0[5:0]]}, 32'h6077);
    chk("after_stop_addr", {24'd0, reg_addr}, 32'h61);

    // 1-clk low pulse on SDA while SCL is high
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h40, a0);
    sda_ctl = 1'b1; clks(Q);
    scl_ctl = 1'b1; clks(Q);
    sda_ctl = 1'b0; clks(1);
    sda_ctl = 1'b1; clks(Q - 1);
    scl_ctl = 1'b0; clks(Q);
`ifdef I2C_GLITCH_FILTER_EN
    chk("glitch_busy", {31'd0, busy}, 1);
`else
    chk("glitch_busy", {31'd0, busy}, 0);
`endif
    i2c_stop();
    clks(10);
    chk("glitch_busy_after_stop", {31'd0, busy}, 0);
    chk("glitch_nwr", wr_cnt - w0, 0);

    // asynchronous reset while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 6);
    sda_ctl = 1'b1; clks(Q);
    scl_ctl = 1'b1; clks(Q);
    chk("pre_reset_ack_oe", {31'd0, sda_oe}, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_oe", {31'd0, sda_oe}, 0);
    chk("async_reset_addr", {24'd0, reg_addr}, 0);
    chk("async_reset_busy", {31'd0, busy}, 0);
    clks(3);
    scl_ctl = 1'b1; sda_ctl = 1'b1;
    reset = 1'b1;
    clks(10);
    chk("post_reset_oe", {31'd0, sda_oe}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/amp_i2c_target.md
Name: amp_i2c_target

Overview:
- I2C target (slave) endpoint for the amplifier front end. Decodes bus traffic from an external I2C controller and drives an 8-bit-address register-file port.
- Protocol: write = addr+W, register pointer, N data bytes. Read = addr+R, N data bytes from the current pointer.
- Fully synchronous to clk: scl/sda are oversampled, no logic is clocked by scl. Used for bench loopback against the config master and as the amp-side control interface.

Parameters:
- SLAVE_ADDR, 7'h20, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on scl_in and sda_in (minimum 2).

Ports:
- clk  in  1  system clock; at least 8x the scl frequency.
- reset  in  1  asynchronous, active-low.
- scl_in  in  1  raw bus SCL level.
- sda_in  in  1  raw bus SDA level.
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad is open-drain).
- reg_addr  out  8  register pointer.
- reg_wdata  out  8  write data; valid while reg_wr_en=1.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read request; reg_rdata is valid the following cycle.
- reg_rdata  in  8  read data.
- busy  out  1  high from an addressed START (address match) until STOP.

Behaviour:
- Reset values: sda_oe=0, reg_addr=8'h00, reg_wdata=8'h00, reg_wr_en=0, reg_rd_en=0, busy=0, state=IDLE, bit counter=0.
- Line conditioning: scl_s and sda_s come from the SYNC_STAGES synchronizer. Previous-sample registers give scl_rise, scl_fall, START (sda_s falling while scl_s=1) and STOP (sda_s rising while scl_s=1).
- Sampling: data is sampled on scl_rise. sda_oe changes only on the cycle after scl_fall, so SDA never changes while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: sda_oe=0; START -> ADDR.
- ADDR: shift 8 bits MSB first.
  - After bit 8: if bits[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy=1.
  - Otherwise go to IDLE and ignore the bus until the next START.
- ADDR_ACK: sda_oe=1 for the ACK clock.
  - If R/W=1: pulse reg_rd_en on the ACK scl_rise and load the shifter from reg_rdata on the next cycle.
  - On the ACK-ending scl_fall: W -> REG; R -> RDATA, driving the MSB.
- REG: shift 8 bits; reg_addr is loaded with the byte on the 8th scl_rise; -> REG_ACK.
- REG_ACK: drive ACK, then -> WDATA.
- WDATA: shift 8 bits. On the 8th scl_rise, set reg_wdata=byte and pulse reg_wr_en for 1 cycle using the current reg_addr; reg_addr increments on the following cycle. -> WDATA_ACK.
- WDATA_ACK: drive ACK, then -> WDATA. Byte count is unlimited.
- RDATA: sda_oe = ~shifter[7] per bit, shifting on each scl_fall. After 8 bits, release SDA -> RDATA_ACK.
- RDATA_ACK: sample the controller's ACK on scl_rise.
  - ACK (0): increment reg_addr, pulse reg_rd_en, reload the shifter the next cycle, then -> RDATA.
  - NACK (1): -> IDLE with SDA released.
- reg_addr arithmetic: 8-bit modulo, 8'hFF+1 = 8'h00.
- STOP in any state: -> IDLE, sda_oe=0, busy=0 on the next cycle; reg_addr is retained.
- Repeated START in any state: -> ADDR, sda_oe=0; reg_addr is retained, so a write-pointer then restart-read sequence works.
- Simultaneous events: START/STOP detection takes priority over scl_rise processing in the same cycle.
- Reset mid-transfer: all registers return to reset values immediately and SDA is released.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: after synchronization, scl_s and sda_s update only when the raw synchronized value has been stable for 3 consecutive clk cycles. Pulses of 2 clk or less are rejected. Edge-detect latency grows by 3 cycles.
- Undefined: the synchronizer output feeds edge detection directly.

Test Plan:
- Write: START, 0x40 (addr 0x20+W), 0x40, 0x18, STOP -> ACK on all 3 bytes; one reg_wr_en with reg_addr=0x40, reg_wdata=0x18; reg_addr=0x41 after; busy drops after STOP.
- Burst write with wrap: pointer 0xFE, data 0x11,0x22,0x33 -> writes at 0xFE, 0xFF, 0x00; final reg_addr=0x01.
- Restart read: write pointer 0x35, repeated START, 0x41, read 2 bytes (controller ACK then NACK) with reg_rdata model mem[0x35]=0x08, mem[0x36]=0xA5 -> SDA shows 0x08 then 0xA5; released after NACK.
- Address mismatch: START, 0x42 (addr 0x21) -> no ACK (sda_oe stays 0); no strobes; busy=0.
- STOP mid-data byte after 4 bits -> IDLE, no reg_wr_en, sda_oe=0; a following valid transaction completes normally.
- Glitch (macro defined): 1-clk low pulse on SDA while SCL high -> no START/STOP detected. Macro undefined -> a false STOP is detected.
